key_event: RTL and testbench

KEY_EVENT -- requirements
Module: key_event

---
 rtl/key_pkg.sv | 32 +++
 rtl/key_edge.sv | 22 ++
 rtl/key_event.sv | 123 ++++++++++++
 tb/tb_key_event.sv | 174 +++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared types and default timing for the key gesture detector.
// Holds the FSM state encoding, the output pulse bundle and the counter sizing helper.
package key_pkg;

  localparam int unsigned LONG_CYC_DEF   = 20000;
  localparam int unsigned DBL_CYC_DEF    = 10000;
  localparam int unsigned REPEAT_CYC_DEF = 5000;

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    LONG_HOLD,
    GAP,
    PRESS2
  } key_state_e;

  typedef struct packed {
    logic press;
    logic short_p;
    logic long_p;
    logic repeat_p;
    logic double_p;
  } key_pulses_t;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Registers the debounced key level once and derives single-cycle rise/fall strobes.
// btn_q comes out of reset high so a key already held at reset release is not a press.
module key_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic rise,
  output logic fall
);

  logic btn_q;

  // NOTE: sequential state always uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) btn_q <= 1'b1;
    else        btn_q <= btn_level;
  end

  assign rise = btn_level & ~btn_q;
  assign fall = ~btn_level & btn_q;

endmodule

// File: rtl/key_event.sv
// Key gesture detector: classifies a debounced key into press, short, long,
// auto-repeat and double-click events, each as a registered one-cycle pulse.
module key_event
  import key_pkg::*;
#(
  parameter int unsigned LONG_CYC   = LONG_CYC_DEF,
  parameter int unsigned DBL_CYC    = DBL_CYC_DEF,
  parameter int unsigned REPEAT_CYC = REPEAT_CYC_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_level,
  output logic press_pulse,
  output logic short_pulse,
  output logic long_pulse,
  output logic repeat_pulse,
  output logic double_pulse
);

  localparam int unsigned CNT_MAX = max3(LONG_CYC, DBL_CYC, REPEAT_CYC);
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST    = CNT_W'(DBL_CYC - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYC - 1);

  logic rise;
  logic fall;

  key_state_e      state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  key_pulses_t     pulses_n, pulses_q;

  key_edge u_edge (
    .clk       (clk),
    .rst_n     (rst_n),
    .btn_level (btn_level),
    .rise      (rise),
    .fall      (fall)
  );

  // NOTE: every signal written here gets a default first, so no path can infer a latch.
  always_comb begin
    state_n  = state;
    cnt_n    = cnt + CNT_W'(1);
    pulses_n = '0;

    unique case (state)
      IDLE: begin
        cnt_n = '0;
        if (rise) begin
          state_n        = PRESS1;
          pulses_n.press = 1'b1;
        end
      end

      // A release on the threshold cycle still counts as a short click.
      PRESS1: begin
        if (fall) begin
          state_n = GAP;
          cnt_n   = '0;
        end else if (cnt == LONG_LAST && btn_level) begin
          state_n         = LONG_HOLD;
          cnt_n           = '0;
          pulses_n.long_p = 1'b1;
        end
      end

      LONG_HOLD: begin
        if (fall) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == REPEAT_LAST) begin
          cnt_n             = '0;
          pulses_n.repeat_p = 1'b1;
        end
      end

      // A second press on the timeout cycle still counts as a double click.
      GAP: begin
        if (rise) begin
          state_n           = PRESS2;
          cnt_n             = '0;
          pulses_n.press    = 1'b1;
          pulses_n.double_p = 1'b1;
        end else if (cnt == DBL_LAST) begin
          state_n          = IDLE;
          cnt_n            = '0;
          pulses_n.short_p = 1'b1;
        end
      end

      PRESS2: begin
        cnt_n = '0;
        if (fall) state_n = IDLE;
      end

      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      pulses_q <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      pulses_q <= pulses_n;
    end
  end

  assign press_pulse  = pulses_q.press;
  assign short_pulse  = pulses_q.short_p;
  assign long_pulse   = pulses_q.long_p;
  assign repeat_pulse = pulses_q.repeat_p;
  assign double_pulse = pulses_q.double_p;

endmodule

// File: tb/tb_key_event.sv
// Self-checking bench for key_event with LONG_CYC=8, DBL_CYC=6, REPEAT_CYC=4.
// Expected pulses are queued with their absolute cycle when a gesture is driven.
module tb_key_event;

  localparam logic [4:0] P = 5'b10000;
  localparam logic [4:0] S = 5'b01000;
  localparam logic [4:0] L = 5'b00100;
  localparam logic [4:0] R = 5'b00010;
  localparam logic [4:0] D = 5'b00001;

  typedef struct {
    int         scen;
    logic       level;
    int         cycles;
  } step_t;

  typedef struct {
    int         scen;
    int         offset;
    logic [4:0] outs;
  } exp_t;

  typedef struct {
    int         cyc;
    logic [4:0] outs;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  logic btn_level;
  logic press_pulse, short_pulse, long_pulse, repeat_pulse, double_pulse;
  logic [4:0] outs;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];

  step_t steps [0:11];
  exp_t  evs   [0:10];
  string names [0:3];

  key_event #(
    .LONG_CYC   (8),
    .DBL_CYC    (6),
    .REPEAT_CYC (4)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .btn_level    (btn_level),
    .press_pulse  (press_pulse),
    .short_pulse  (short_pulse),
    .long_pulse   (long_pulse),
    .repeat_pulse (repeat_pulse),
    .double_pulse (double_pulse)
  );

  assign outs = {press_pulse, short_pulse, long_pulse, repeat_pulse, double_pulse};

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (|outs) obs_q.push_back('{cyc, outs});
  end

  task automatic check(input string name, input int act, input int req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic step(input logic level, input int n);
    for (int i = 0; i < n; i++) begin
      btn_level = level;
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int at, input logic [4:0] o);
    exp_q.push_back('{at, o});
  endtask

  task automatic drain(input string tag);
    ev_t e;
    int  idx;
    int  act;
    while (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      idx = -1;
      for (int i = 0; i < obs_q.size(); i++)
        if (idx < 0 && obs_q[i].cyc == e.cyc) idx = i;
      if (idx >= 0) begin
        act = int'(obs_q[idx].outs);
        obs_q.delete(idx);
      end else begin
        act = 0;
      end
      check($sformatf("%s_cyc%0d", tag, e.cyc), act, int'(e.outs));
    end
    check({tag, "_extra_pulses"}, obs_q.size(), 0);
    obs_q.delete();
  endtask

  initial begin
    int c0;

    steps = '{
      '{0, 1'b1, 3},  '{0, 1'b0, 14},
      '{1, 1'b1, 22}, '{1, 1'b0, 12},
      '{2, 1'b1, 2},  '{2, 1'b0, 3},  '{2, 1'b1, 12}, '{2, 1'b0, 12},
      '{3, 1'b1, 8},  '{3, 1'b0, 6},  '{3, 1'b1, 2},  '{3, 1'b0, 12}
    };
    evs = '{
      '{0, 1, P},  '{0, 10, S},
      '{1, 1, P},  '{1, 9, L},  '{1, 13, R}, '{1, 17, R}, '{1, 21, R},
      '{2, 1, P},  '{2, 6, P | D},
      '{3, 1, P},  '{3, 15, P | D}
    };
    names = '{"short", "long_repeat", "double", "edge_ties"};

    // Reset with the key already held: no press may appear on release.
    rst_n     = 1'b0;
    btn_level = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("reset_outs", int'(outs), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 5);
    step(1'b0, 12);
    drain("held_at_reset");

    for (int s = 0; s < 4; s++) begin
      c0 = cyc;
      for (int e = 0; e < 11; e++)
        if (evs[e].scen == s) expect_at(c0 + evs[e].offset, evs[e].outs);
      for (int k = 0; k < 12; k++)
        if (steps[k].scen == s) step(steps[k].level, steps[k].cycles);
      drain(names[s]);
    end

    // Reset inside LONG_HOLD with the key still held, then a fresh short click.
    c0 = cyc;
    expect_at(c0 + 1, P);
    expect_at(c0 + 9, L);
    expect_at(c0 + 29, P);
    expect_at(c0 + 37, S);
    step(1'b1, 12);
    rst_n = 1'b0;
    #1;
    check("mid_reset_outs", int'(outs), 0);
    step(1'b1, 3);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 10);
    step(1'b0, 3);
    step(1'b1, 2);
    step(1'b0, 12);
    drain("reset_in_hold");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
